timer_event: RTL

- Downstream stage of the timer core: consumes its `curr_timer` and `running` outputs and turns them into sticky event status, an interrupt request and a capture register.
- Detects expiry, software stop, 32-bit wrap in free-running mode, and NUM_CMP compare matches.
- Sits between the timer core and the timer register interface, which owns the enables, clears and readback.

---
 rtl/timer_event_pkg.sv | 25 ++
 rtl/timer_event_cmp.sv | 33 +++
 rtl/timer_event.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/timer_event_pkg.sv
// -----------------------------------------------------------------------------
// timer_event_pkg
// Shared constants and helpers for the timer event stage.
//   TIMER_WIDTH   : width of the timer count
//   EV_*          : bit positions of the events in the status/overrun vectors
//   NUM_FIXED_EV  : number of events that are not compare channels
// -----------------------------------------------------------------------------
package timer_event_pkg;

    localparam int TIMER_WIDTH  = 32;
    localparam int NUM_FIXED_EV = 3;

    localparam int EV_EXPIRED   = 0;
    localparam int EV_STOPPED   = 1;
    localparam int EV_WRAP      = 2;
    localparam int EV_CMP_BASE  = 3;

    typedef logic [TIMER_WIDTH-1:0] timer_t;

    // True when the count stepped from all-ones straight to zero.
    function automatic logic is_wrap(input timer_t prev, input timer_t curr);
        return (prev == {TIMER_WIDTH{1'b1}}) && (curr == {TIMER_WIDTH{1'b0}});
    endfunction

endpackage

// File: rtl/timer_event_cmp.sv
// -----------------------------------------------------------------------------
// timer_event_cmp
// One compare channel. Fires for exactly one cycle per count value that equals
// the compare value while the timer runs.
//   cmp_en       : channel enable
//   cmp_value    : value to match
//   curr_timer   : current timer count
//   prev_timer   : timer count of the previous cycle
//   running      : timer running this cycle
//   prev_running : timer running in the previous cycle
//   match        : single-cycle match (combinational, registered by the top)
// -----------------------------------------------------------------------------
module timer_event_cmp
    import timer_event_pkg::*;
(
    input  logic                   cmp_en,
    input  logic [TIMER_WIDTH-1:0] cmp_value,
    input  logic [TIMER_WIDTH-1:0] curr_timer,
    input  logic [TIMER_WIDTH-1:0] prev_timer,
    input  logic                   running,
    input  logic                   prev_running,
    output logic                   match
);

    logic first_s;

    // A prescaled timer holds a value for several cycles; only the first cycle
    // of a value counts. The first running cycle always qualifies so that a
    // start directly at the compare value (e.g. 0) still matches.
    assign first_s = (curr_timer != prev_timer) || !prev_running;
    assign match   = cmp_en && running && (curr_timer == cmp_value) && first_s;

endmodule

// File: rtl/timer_event.sv
// -----------------------------------------------------------------------------
// timer_event
// Turns the timer core's count/running outputs into sticky event status, an
// interrupt request and a capture register.
// Parameters:
//   NUM_CMP : number of compare channels (1..4)
//   NUM_EV  : derived event count (3 + NUM_CMP), not to be overridden
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   curr_timer     : timer count from the timer core
//   running        : running flag from the timer core
//   stop           : the stop pulse also sent to the timer core
//   cmp_value      : compare values, channel i at [32i+31:32i]
//   cmp_en         : per-channel compare enable
//   irq_en         : per-event interrupt enable
//   status_clr     : write-1-to-clear pulses for status
//   capture        : snapshot curr_timer
//   capture_clr    : clear capture_valid
//   status         : sticky events [0] EXPIRED [1] STOPPED [2] WRAP [3+i] CMP_i
//   overrun        : sticky overrun per event (TIMER_EVENT_OVERRUN_EN only)
//   irq            : interrupt request
//   capture_value  : last captured count
//   capture_valid  : capture holds unread data
// Build option: define TIMER_EVENT_OVERRUN_EN to build the overrun registers;
// otherwise overrun is constant 0.
// -----------------------------------------------------------------------------
module timer_event
    import timer_event_pkg::*;
#(
    parameter  int NUM_CMP = 2,
    localparam int NUM_EV  = NUM_FIXED_EV + NUM_CMP
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [TIMER_WIDTH-1:0]         curr_timer,
    input  logic                           running,
    input  logic                           stop,
    input  logic [TIMER_WIDTH*NUM_CMP-1:0] cmp_value,
    input  logic [NUM_CMP-1:0]             cmp_en,
    input  logic [NUM_EV-1:0]              irq_en,
    input  logic [NUM_EV-1:0]              status_clr,
    input  logic                           capture,
    input  logic                           capture_clr,
    output logic [NUM_EV-1:0]              status,
    output logic [NUM_EV-1:0]              overrun,
    output logic                           irq,
    output logic [TIMER_WIDTH-1:0]         capture_value,
    output logic                           capture_valid
);

    logic                   prev_running_r;
    logic [TIMER_WIDTH-1:0] prev_timer_r;
    logic                   stop_pending_r;
    logic [NUM_EV-1:0]      status_r;
    logic                   irq_r;
    logic [TIMER_WIDTH-1:0] capture_value_r;
    logic                   capture_valid_r;

    logic                    fall_s;
    logic [NUM_FIXED_EV-1:0] fixed_ev_s;
    logic [NUM_CMP-1:0]      cmp_match_s;
    logic [NUM_EV-1:0]       ev_s;
    logic [NUM_EV-1:0]       status_next_s;

    // A stop can arrive one cycle before running drops, so it is remembered
    // until the timer is seen idle; that separates STOPPED from EXPIRED.
    assign fall_s                  = prev_running_r && !running;
    assign fixed_ev_s[EV_EXPIRED]  = fall_s && !stop_pending_r && !stop;
    assign fixed_ev_s[EV_STOPPED]  = fall_s && (stop_pending_r || stop);
    assign fixed_ev_s[EV_WRAP]     = running && prev_running_r &&
                                     is_wrap(prev_timer_r, curr_timer);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CMP; gi++) begin : g_cmp
            timer_event_cmp u_cmp (
                .cmp_en       (cmp_en[gi]),
                .cmp_value    (cmp_value[TIMER_WIDTH*gi +: TIMER_WIDTH]),
                .curr_timer   (curr_timer),
                .prev_timer   (prev_timer_r),
                .running      (running),
                .prev_running (prev_running_r),
                .match        (cmp_match_s[gi])
            );
        end
    endgenerate

    assign ev_s = {cmp_match_s, fixed_ev_s};

    // Next status: a new event beats a clear of the same bit.
    always_comb begin
        status_next_s = (status_r & ~status_clr) | ev_s;
    end

    // History of the timer core outputs used for edge/first-cycle detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_running_r <= 1'b0;
            prev_timer_r   <= {TIMER_WIDTH{1'b0}};
            stop_pending_r <= 1'b0;
        end else begin
            prev_running_r <= running;
            prev_timer_r   <= curr_timer;
            if (stop && running) begin
                stop_pending_r <= 1'b1;
            end else if (!running) begin
                stop_pending_r <= 1'b0;
            end else begin
                stop_pending_r <= stop_pending_r;
            end
        end
    end

    // Sticky status and the interrupt, both derived from the same next value
    // so irq rises in the same cycle as the status bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            status_r <= {NUM_EV{1'b0}};
            irq_r    <= 1'b0;
        end else begin
            status_r <= status_next_s;
            irq_r    <= |(status_next_s & irq_en);
        end
    end

    // Capture register; a capture in the same cycle as capture_clr wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            capture_value_r <= {TIMER_WIDTH{1'b0}};
            capture_valid_r <= 1'b0;
        end else if (capture) begin
            capture_value_r <= curr_timer;
            capture_valid_r <= 1'b1;
        end else if (capture_clr) begin
            capture_value_r <= capture_value_r;
            capture_valid_r <= 1'b0;
        end else begin
            capture_value_r <= capture_value_r;
            capture_valid_r <= capture_valid_r;
        end
    end

`ifdef TIMER_EVENT_OVERRUN_EN
    logic [NUM_EV-1:0] overrun_r;
    logic [NUM_EV-1:0] overrun_next_s;

    // Overrun: event hits an already-set, uncleared bit. A clear only removes
    // overrun when the event is not firing in that same cycle.
    always_comb begin
        overrun_next_s = (overrun_r & ~(status_clr & ~ev_s)) |
                         (ev_s & status_r & ~status_clr);
    end

    // Overrun register.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_r <= {NUM_EV{1'b0}};
        end else begin
            overrun_r <= overrun_next_s;
        end
    end

    assign overrun = overrun_r;
`else
    assign overrun = {NUM_EV{1'b0}};
`endif

    assign status        = status_r;
    assign irq           = irq_r;
    assign capture_value = capture_value_r;
    assign capture_valid = capture_valid_r;

endmodule
